// File: rtl/polar_averager_pkg.sv
// Shared DSP definitions: polar beat field layout and phase scaling,
// common to the CORDIC stage and the polar averager.
package polar_averager_pkg;

  localparam int PHASE_W    = 16;
  localparam int RADIUS_W   = 16;
  localparam int PHASE_MSB  = 31;
  localparam int PHASE_LSB  = 16;
  localparam int RADIUS_MSB = 15;
  localparam int RADIUS_LSB = 0;

  // 2^16 phase units span one full turn (360 degrees).
  localparam int unsigned PHASE_FULL_SCALE = 32'd1 << PHASE_W;

endpackage

// File: rtl/polar_averager.sv
// Averages blocks of 2^LOG2_N polar beats; phase is averaged as a signed
// offset from the block's first phase so that wrap-around at 0/360 is handled.
module polar_averager
  import polar_averager_pkg::*;
#(
  parameter int LOG2_N                 = 4,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  input  logic [3:0]                        s00_axis_tstrb,
  output logic                              s00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic [3:0]                        m00_axis_tstrb,
  input  logic                              m00_axis_tready,
  output logic                              frame_err
);

  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int AW = PHASE_W + LOG2_N;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);

  // Handshake: s00_axis_tready drops only while a finished result is stalled
  // downstream; a beat is accepted in any cycle with tvalid && tready high.
  logic accept;
  assign s00_axis_tready = !(m00_axis_tvalid && !m00_axis_tready);
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign m00_axis_tstrb  = 4'hF;

  logic [CW-1:0]         count;
  logic [AW-1:0]         rad_acc;
  logic signed [AW-1:0]  diff_acc;
  logic [PHASE_W-1:0]    ref_phase;

  logic [PHASE_W-1:0]    phase_in;
  logic [RADIUS_W-1:0]   radius_in;
  logic                  first_beat;
  logic                  last_beat;
  logic [PHASE_W-1:0]    ref_cur;
  logic signed [PHASE_W-1:0] diff_in;
  logic [AW-1:0]         rad_sum;
  logic signed [AW-1:0]  diff_sum;
  logic [AW-1:0]         rad_mean;
  logic signed [AW-1:0]  diff_mean;
  logic [PHASE_W-1:0]    out_phase;
  logic [RADIUS_W-1:0]   out_radius;

  assign phase_in   = s00_axis_tdata[PHASE_MSB:PHASE_LSB];
  assign radius_in  = s00_axis_tdata[RADIUS_MSB:RADIUS_LSB];
  assign first_beat = (count == '0);
  assign last_beat  = (count == LAST_CNT);

  // The first beat of a block is its own reference, so its offset is zero.
  assign ref_cur    = first_beat ? phase_in : ref_phase;
  assign diff_in    = phase_in - ref_cur;

  assign rad_sum    = rad_acc + AW'(radius_in);
  assign diff_sum   = diff_acc + AW'(diff_in);
  assign rad_mean   = rad_sum >> LOG2_N;
  assign diff_mean  = diff_sum >>> LOG2_N;
  assign out_radius = rad_mean[RADIUS_W-1:0];
  assign out_phase  = ref_cur + diff_mean[PHASE_W-1:0];

  logic unused_ok;
  assign unused_ok = ^{s00_axis_tstrb, rad_mean, diff_mean};

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      count           <= '0;
      rad_acc         <= '0;
      diff_acc        <= '0;
      ref_phase       <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      frame_err       <= 1'b0;
    end else begin
      if (m00_axis_tvalid && m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (last_beat) begin
          m00_axis_tdata  <= {out_phase, out_radius};
          m00_axis_tlast  <= s00_axis_tlast;
          m00_axis_tvalid <= 1'b1;
          count           <= '0;
          rad_acc         <= '0;
          diff_acc        <= '0;
        end else if (s00_axis_tlast) begin
          // Frame ended mid-block: drop the partial block.
          count     <= '0;
          rad_acc   <= '0;
          diff_acc  <= '0;
          frame_err <= 1'b1;
        end else begin
          count    <= count + CW'(1);
          rad_acc  <= rad_sum;
          diff_acc <= diff_sum;
          if (first_beat) begin
            ref_phase <= phase_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_polar_averager.sv
// Randomised and directed bench for polar_averager (N = 4) with a
// queue-based block-average reference model.
module tb_polar_averager;

  logic        clk = 1'b0;
  logic        areset;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tstrb;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;
  logic        m_tready;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;

  logic        hold_low   = 1'b0;
  logic        rand_ready = 1'b0;
  logic        mon_en     = 1'b0;

  int          ph_q[$];
  int          rd_q[$];
  logic        model_ferr = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] last_out = '0;

  polar_averager #(.LOG2_N(2)) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(areset),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tdata (s_tdata),
    .s00_axis_tlast (s_tlast),
    .s00_axis_tstrb (s_tstrb),
    .s00_axis_tready(s_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tlast (m_tlast),
    .m00_axis_tstrb (m_tstrb),
    .m00_axis_tready(m_tready),
    .frame_err      (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_tready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] block_average(input logic last);
    int ref_ph, dsum, rsum, d, mean, ph;
    ref_ph = ph_q[0];
    dsum = 0;
    rsum = 0;
    for (int i = 0; i < 4; i++) begin
      d = (ph_q[i] - ref_ph) & 32'hFFFF;
      if (d >= 32768) d = d - 65536;
      dsum += d;
      rsum += rd_q[i];
    end
    mean = (dsum >= 0) ? dsum / 4 : -((-dsum + 3) / 4);
    ph = ((ref_ph + mean) % 65536 + 65536) % 65536;
    return {last, ph[15:0], 16'(rsum / 4)};
  endfunction

  task automatic model_accept(input logic [31:0] data, input logic last);
    ph_q.push_back(int'(data[31:16]));
    rd_q.push_back(int'(data[15:0]));
    if (ph_q.size() == 4) begin
      exp_q.push_back(block_average(last));
      ph_q.delete();
      rd_q.delete();
    end else if (last) begin
      model_ferr = 1'b1;
      ph_q.delete();
      rd_q.delete();
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    check("out_tstrb", 64'(m_tstrb), 64'hF);
    if (mon_en) begin
      if (areset) begin
        ph_q.delete();
        rd_q.delete();
        exp_q.delete();
        model_ferr = 1'b0;
      end else begin
        check("out_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
        if (m_tvalid && exp_q.size() != 0)
          check("out_data", 64'({m_tlast, m_tdata}), 64'(exp_q[0]));
        check("frame_err", 64'(frame_err), 64'(model_ferr));
        check("in_tready", 64'(s_tready), 64'(!(exp_q.size() != 0 && !m_tready)));
        if (m_tvalid && m_tready && exp_q.size() != 0) begin
          last_out = {m_tlast, m_tdata};
          void'(exp_q.pop_front());
        end
        if (s_tvalid && s_tready) model_accept(s_tdata, s_tlast);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] ph, input logic [15:0] rd, input logic last);
    int n;
    bit done;
    s_tvalid = 1'b1;
    s_tdata  = {ph, rd};
    s_tlast  = last;
    s_tstrb  = 4'($urandom);
    n = 0;
    done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (s_tready) done = 1;
      else n++;
    end
    if (!done) check("send_timeout", 64'(n), 64'(0));
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'(1));
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tstrb  = '0;
    m_tready = 1'b1;
    mon_en   = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_ferr", 64'(frame_err), 64'(0));
    tick();

    // Plain average with tlast on the block's final beat.
    send_beat(16'h1000, 16'd100, 1'b0);
    send_beat(16'h1000, 16'd200, 1'b0);
    send_beat(16'h1000, 16'd300, 1'b0);
    send_beat(16'h1000, 16'd400, 1'b1);
    @(negedge clk);
    check("lat_tvalid", 64'(m_tvalid), 64'(1));
    tick();
    wait_drain();
    check("dir_basic", 64'(last_out), 64'({1'b1, 16'h1000, 16'd250}));

    // Phases straddling zero must average to zero, not half a turn.
    send_beat(16'hFFF0, 16'd1000, 1'b0);
    send_beat(16'h0010, 16'd1000, 1'b0);
    send_beat(16'hFFF0, 16'd1000, 1'b0);
    send_beat(16'h0010, 16'd1000, 1'b0);
    wait_drain();
    check("dir_wrap", 64'(last_out), 64'({1'b0, 16'h0000, 16'd1000}));

    // Full-scale radius.
    repeat (4) send_beat(16'h8000, 16'hFFFF, 1'b0);
    wait_drain();
    check("dir_fullscale", 64'(last_out), 64'({1'b0, 16'h8000, 16'hFFFF}));

    // Downstream stall with a beat waiting upstream.
    hold_low = 1'b1;
    tick();
    send_beat(16'h0100, 16'd10, 1'b0);
    send_beat(16'h0100, 16'd20, 1'b0);
    send_beat(16'h0100, 16'd30, 1'b0);
    send_beat(16'h0100, 16'd40, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = {16'h4000, 16'd1};
    s_tlast  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_tready", 64'(s_tready), 64'(0));
      check("stall_tvalid", 64'(m_tvalid), 64'(1));
      check("stall_tdata", 64'(m_tdata), 64'({16'h0100, 16'd25}));
    end
    hold_low = 1'b0;
    send_beat(16'h4000, 16'd1, 1'b0);
    send_beat(16'h4000, 16'd2, 1'b0);
    send_beat(16'h4000, 16'd3, 1'b0);
    send_beat(16'h4000, 16'd5, 1'b0);
    wait_drain();
    check("dir_after_stall", 64'(last_out), 64'({1'b0, 16'h4000, 16'd2}));

    // Short frame: partial block dropped, error flagged.
    send_beat(16'h2000, 16'd77, 1'b0);
    send_beat(16'h2000, 16'd77, 1'b1);
    repeat (3) tick();
    check("short_noout", 64'(m_tvalid), 64'(0));
    check("short_ferr", 64'(frame_err), 64'(1));
    repeat (4) send_beat(16'h2000, 16'd8, 1'b0);
    wait_drain();
    check("dir_after_short", 64'(last_out), 64'({1'b0, 16'h2000, 16'd8}));

    // Reset in the middle of a block.
    send_beat(16'h1234, 16'd99, 1'b0);
    send_beat(16'h1234, 16'd99, 1'b0);
    do_reset();
    @(negedge clk);
    check("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("mid_rst_tdata", 64'(m_tdata), 64'(0));
    check("mid_rst_ferr", 64'(frame_err), 64'(0));
    tick();
    send_beat(16'h0500, 16'd4, 1'b0);
    send_beat(16'h0500, 16'd8, 1'b0);
    send_beat(16'h0500, 16'd12, 1'b0);
    send_beat(16'h0500, 16'd16, 1'b1);
    wait_drain();
    check("dir_after_rst", 64'(last_out), 64'({1'b1, 16'h0500, 16'd10}));

    // Random blocks, random backpressure, occasional short frames.
    rand_ready = 1'b1;
    for (int b = 0; b < 150; b++) begin
      int len;
      logic [15:0] base;
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 4;
      base = 16'($urandom);
      for (int i = 0; i < len; i++) begin
        logic [15:0] ph;
        logic last;
        if ($urandom_range(0, 3) == 0) ph = 16'($urandom);
        else ph = base + 16'($urandom_range(0, 4096)) - 16'd2048;
        last = (i == len - 1) && (len < 4 || $urandom_range(0, 1) == 1);
        send_beat(ph, 16'($urandom), last);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    rand_ready = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
